// File: rtl/modulation_segment_4_serializer.sv
// Frame serializer: captures ten 32-bit segments on start and streams a fixed
// preamble followed by segments 0..9 over a valid/ready output, with busy/done control.
module modulation_segment_4_serializer #(
  parameter int unsigned PREAMBLE_LEN  = 3,
  parameter logic [31:0] PREAMBLE_WORD = 32'hA5A5_A5A5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] segment_0_i,
  input  logic [31:0] segment_1_i,
  input  logic [31:0] segment_2_i,
  input  logic [31:0] segment_3_i,
  input  logic [31:0] segment_4_i,
  input  logic [31:0] segment_5_i,
  input  logic [31:0] segment_6_i,
  input  logic [31:0] segment_7_i,
  input  logic [31:0] segment_8_i,
  input  logic [31:0] segment_9_i,
  input  logic        out_ready_i,
  output logic [31:0] out_symbol_o,
  output logic [3:0]  out_index_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StSend,
    StDone
  } state_e;

  localparam logic [2:0] PreLen    = 3'(PREAMBLE_LEN);
  localparam logic [3:0] LastSeg   = 4'd9;
  localparam logic [3:0] PreambleIdx = 4'hF;

  state_e      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  seg_cnt_q, seg_cnt_d;
  logic [31:0] capture_q [10];
  logic [31:0] capture_d [10];
  logic [31:0] symbol_q, symbol_d;
  logic [3:0]  index_q, index_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] seg_in [10];
  logic [3:0]  seg_next;
  logic [2:0]  pre_next;
  logic        transfer;

  assign seg_in[0] = segment_0_i;
  assign seg_in[1] = segment_1_i;
  assign seg_in[2] = segment_2_i;
  assign seg_in[3] = segment_3_i;
  assign seg_in[4] = segment_4_i;
  assign seg_in[5] = segment_5_i;
  assign seg_in[6] = segment_6_i;
  assign seg_in[7] = segment_7_i;
  assign seg_in[8] = segment_8_i;
  assign seg_in[9] = segment_9_i;

  assign transfer = valid_q & out_ready_i;
  assign seg_next = seg_cnt_q + 4'd1;
  assign pre_next = pre_cnt_q + 3'd1;

  // Outputs are computed one cycle ahead so every port is driven straight from a flop.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    seg_cnt_d = seg_cnt_q;
    capture_d = capture_q;
    symbol_d  = symbol_q;
    index_d   = index_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start_i) begin
          capture_d = seg_in;
          state_d   = StPreamble;
          pre_cnt_d = 3'd0;
          seg_cnt_d = 4'd0;
          symbol_d  = PREAMBLE_WORD;
          index_d   = PreambleIdx;
          valid_d   = 1'b1;
          last_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      StPreamble: begin
        if (transfer) begin
          pre_cnt_d = pre_next;
          if (pre_next == PreLen) begin
            state_d   = StSend;
            seg_cnt_d = 4'd0;
            symbol_d  = capture_q[0];
            index_d   = 4'd0;
            last_d    = 1'b0;
          end
        end
      end

      StSend: begin
        if (transfer) begin
          if (seg_cnt_q == LastSeg) begin
            state_d = StDone;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            seg_cnt_d = seg_next;
            symbol_d  = capture_q[seg_next];
            index_d   = seg_next;
            last_d    = (seg_next == LastSeg);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pre_cnt_q <= 3'd0;
      seg_cnt_q <= 4'd0;
      symbol_q  <= 32'd0;
      index_q   <= 4'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      seg_cnt_q <= seg_cnt_d;
      symbol_q  <= symbol_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The capture bank is deliberately left out of reset; it is only read after a fresh capture.
  always_ff @(posedge clk_i) begin
    capture_q <= capture_d;
  end

  assign out_symbol_o = symbol_q;
  assign out_index_o  = index_q;
  assign out_valid_o  = valid_q;
  assign out_last_o   = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
